// File: rtl/l2_arb_pkg.sv
// Shared types and constants for the L2 port arbiter between the L1 I-cache and D-cache.
package l2_arb_pkg;

    localparam int S_OFFSET = 5;
    localparam int S_ADDR   = 32;
    localparam int S_LINE   = 8 * (2 ** S_OFFSET);

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    function automatic arb_state_t serve_state(input logic grant);
        return (grant == GRANT_D) ? SERVE_D : SERVE_I;
    endfunction

endpackage

// File: rtl/l2_arb_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side not granted last.
module l2_arb_rr
    import l2_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = GRANT_I;
        case (req)
            2'b01:   grant = GRANT_I;
            2'b10:   grant = GRANT_D;
            2'b11:   grant = ~last_grant;
            default: grant = GRANT_I;
        endcase
    end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 port between the L1 I-cache and D-cache, one line transaction at a time.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int s_offset = S_OFFSET,
    parameter int s_addr   = S_ADDR,
    localparam int s_line  = 8 * (2 ** s_offset)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [s_addr-1:0] i_addr,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [s_addr-1:0] d_addr,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,

    output logic              l2_read,
    output logic              l2_write,
    output logic [s_addr-1:0] l2_addr,
    output logic [s_line-1:0] l2_wdata,
    input  logic [s_line-1:0] l2_rdata,
    input  logic              l2_resp
);

    arb_state_t        state, state_next;
    logic              last_grant, last_grant_next;
    logic              l2_read_next, l2_write_next;
    logic [s_addr-1:0] l2_addr_next;
    logic [s_line-1:0] l2_wdata_next;
    logic              rr_grant, rr_valid;

    l2_arb_rr u_rr (
        .req        ({d_read | d_write, i_read}),
        .last_grant (last_grant),
        .grant      (rr_grant),
        .valid      (rr_valid)
    );

    // The L2 request is always driven from these registers so requester inputs
    // may change freely while a transaction is outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
            l2_addr    <= '0;
            l2_wdata   <= '0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            l2_read    <= l2_read_next;
            l2_write   <= l2_write_next;
            l2_addr    <= l2_addr_next;
            l2_wdata   <= l2_wdata_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        l2_read_next    = l2_read;
        l2_write_next   = l2_write;
        l2_addr_next    = l2_addr;
        l2_wdata_next   = l2_wdata;
        i_resp          = 1'b0;
        d_resp          = 1'b0;
        i_rdata         = '0;
        d_rdata         = '0;

        case (state)
            IDLE: begin
                if (rr_valid) begin
                    state_next = serve_state(rr_grant);
                    if (rr_grant == GRANT_D) begin
                        // A simultaneous read and writeback from the D-cache performs only the write.
                        l2_write_next = d_write;
                        l2_read_next  = ~d_write;
                        l2_addr_next  = d_addr;
                        l2_wdata_next = d_wdata;
                    end else begin
                        l2_write_next = 1'b0;
                        l2_read_next  = 1'b1;
                        l2_addr_next  = i_addr;
                        l2_wdata_next = '0;
                    end
                end
            end

            SERVE_I: begin
                if (l2_resp) begin
                    i_resp          = 1'b1;
                    i_rdata         = l2_rdata;
                    l2_read_next    = 1'b0;
                    l2_write_next   = 1'b0;
                    last_grant_next = GRANT_I;
                    state_next      = IDLE;
                end
            end

            SERVE_D: begin
                if (l2_resp) begin
                    d_resp          = 1'b1;
                    d_rdata         = l2_rdata;
                    l2_read_next    = 1'b0;
                    l2_write_next   = 1'b0;
                    last_grant_next = GRANT_D;
                    state_next      = IDLE;
                end
            end

            default: begin
                state_next    = IDLE;
                l2_read_next  = 1'b0;
                l2_write_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomised bench for l2_arbiter against a transaction-level round-robin reference model.
module tb_l2_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, d_read, d_write, l2_resp;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] d_wdata, l2_rdata;
    logic [255:0] i_rdata, d_rdata, l2_wdata;
    logic         i_resp, d_resp, l2_read, l2_write;
    logic [31:0]  l2_addr;

    int checks = 0;
    int errors = 0;
    int ref_last = 1;
    bit persist = 0;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        bit           stable;
        int           n_i;
        int           n_d;
        logic [255:0] rdata_i;
        logic [255:0] rdata_d;
        bit           zero_ok;
        bit           idle_ok;
    } obs_t;

    l2_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_resp   (i_resp),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_resp   (d_resp),
        .l2_read  (l2_read),
        .l2_write (l2_write),
        .l2_addr  (l2_addr),
        .l2_wdata (l2_wdata),
        .l2_rdata (l2_rdata),
        .l2_resp  (l2_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: lone requester wins, a tie goes to the side that did not win last.
    function automatic int ref_pick(logic ri, logic rd, int last);
        if (ri && rd) return (last == 0) ? 1 : 0;
        if (ri) return 0;
        if (rd) return 1;
        return -1;
    endfunction

    task automatic clear_inputs();
        i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; l2_rdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        @(negedge clk);
        rst = 0;
        ref_last = 1;
    endtask

    // Drives one L2 transaction: entered with requests already applied in an IDLE cycle,
    // returns in the following IDLE cycle with the responded side's request dropped.
    task automatic run_txn(input int lat, input logic [255:0] line, input bit mutate, output obs_t o);
        o.stable = 1; o.n_i = 0; o.n_d = 0; o.rdata_i = 0; o.rdata_d = 0; o.zero_ok = 1;
        @(posedge clk); #1;
        if (persist) begin
            i_read = 1;
            if (!d_read && !d_write) begin
                d_write = 1'($urandom_range(0, 1));
                d_read  = !d_write;
            end
        end
        if (mutate) begin
            i_addr = $urandom; d_addr = $urandom; d_wdata = rand_line();
        end
        o.rd = l2_read; o.wr = l2_write; o.addr = l2_addr; o.wdata = l2_wdata;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == lat) begin l2_resp = 1; l2_rdata = line; end
            @(negedge clk);
            if (l2_read !== o.rd || l2_write !== o.wr || l2_addr !== o.addr || l2_wdata !== o.wdata)
                o.stable = 0;
            if (i_resp === 1'b1) begin o.n_i++; o.rdata_i = i_rdata; end
            else if (i_rdata !== '0) o.zero_ok = 0;
            if (d_resp === 1'b1) begin o.n_d++; o.rdata_d = d_rdata; end
            else if (d_rdata !== '0) o.zero_ok = 0;
        end
        @(posedge clk); #1;
        l2_resp = 0;
        l2_rdata = rand_line();
        if (o.n_i > 0) i_read = 0;
        if (o.n_d > 0) begin d_read = 0; d_write = 0; end
        @(negedge clk);
        o.idle_ok = !l2_read && !l2_write && !i_resp && !d_resp && i_rdata == '0 && d_rdata == '0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        #1;
        checks++;
        if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {l2_read, l2_write, i_resp, d_resp});
        end
        checks++;
        if (l2_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_addr: got %h expected 0", l2_addr);
        end
        checks++;
        if (l2_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            errors++; $display("[TB] FAIL reset_data: wdata %h i_rdata %h d_rdata %h expected 0", l2_wdata, i_rdata, d_rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        ref_last = 1;
    endtask

    task automatic test_i_read_alone();
        obs_t o;
        logic [255:0] pat = {32{8'hA5}};
        i_read = 1; i_addr = 32'h0000_1000;
        run_txn(3, pat, 0, o);
        checks++;
        if (o.rd !== 1'b1 || o.wr !== 1'b0) begin
            errors++; $display("[TB] FAIL i_alone_op: got rd=%b wr=%b expected rd=1 wr=0", o.rd, o.wr);
        end
        checks++;
        if (o.addr !== 32'h0000_1000) begin
            errors++; $display("[TB] FAIL i_alone_addr: got %h expected 00001000", o.addr);
        end
        checks++;
        if (!o.stable) begin
            errors++; $display("[TB] FAIL i_alone_hold: got unstable expected stable");
        end
        checks++;
        if (o.n_i != 1 || o.n_d != 0) begin
            errors++; $display("[TB] FAIL i_alone_resp: got i=%0d d=%0d expected i=1 d=0", o.n_i, o.n_d);
        end
        checks++;
        if (o.rdata_i !== pat) begin
            errors++; $display("[TB] FAIL i_alone_rdata: got %h expected %h", o.rdata_i, pat);
        end
        checks++;
        if (!o.idle_ok || !o.zero_ok) begin
            errors++; $display("[TB] FAIL i_alone_idle: got idle=%0d zero=%0d expected 1 1", o.idle_ok, o.zero_ok);
        end
        ref_last = 0;
    endtask

    task automatic test_tie_after_reset();
        obs_t o1, o2;
        logic [31:0]  ia;
        logic [255:0] l1 = rand_line();
        logic [255:0] l2 = rand_line();
        do_reset();
        ia = $urandom;
        i_read = 1; i_addr = ia;
        d_write = 1; d_addr = 32'h0000_2000; d_wdata = {32{8'h5A}};
        run_txn(2, l1, 0, o1);
        checks++;
        if (o1.rd !== 1'b1 || o1.wr !== 1'b0 || o1.addr !== ia || o1.n_i != 1 || o1.n_d != 0) begin
            errors++; $display("[TB] FAIL tie_first: got rd=%b wr=%b addr=%h i=%0d d=%0d expected I read of %h",
                               o1.rd, o1.wr, o1.addr, o1.n_i, o1.n_d, ia);
        end
        run_txn(2, l2, 0, o2);
        checks++;
        if (o2.wr !== 1'b1 || o2.rd !== 1'b0 || o2.addr !== 32'h0000_2000 || o2.n_d != 1 || o2.n_i != 0) begin
            errors++; $display("[TB] FAIL tie_second: got rd=%b wr=%b addr=%h i=%0d d=%0d expected D write of 00002000",
                               o2.rd, o2.wr, o2.addr, o2.n_i, o2.n_d);
        end
        checks++;
        if (o2.wdata !== {32{8'h5A}}) begin
            errors++; $display("[TB] FAIL tie_wdata: got %h expected 5A line", o2.wdata);
        end
        ref_last = 1;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        obs_t o;
        int   w;
        logic [31:0]  ea;
        logic [255:0] ln;
        do_reset();
        persist = 1;
        i_read = 1; i_addr = $urandom;
        d_read = 1; d_addr = $urandom;
        for (int t = 0; t < 6; t++) begin
            w  = ref_pick(i_read, d_read | d_write, ref_last);
            ea = (w == 1) ? d_addr : i_addr;
            ln = rand_line();
            run_txn(1 + $urandom_range(0, 3), ln, 1, o);
            checks++;
            if (w != (t % 2) || o.n_i != ((w == 0) ? 1 : 0) || o.n_d != ((w == 1) ? 1 : 0)) begin
                errors++; $display("[TB] FAIL b2b_grant[%0d]: got i=%0d d=%0d expected side %0d", t, o.n_i, o.n_d, t % 2);
            end
            checks++;
            if (o.addr !== ea || ((w == 0) ? o.rdata_i : o.rdata_d) !== ln) begin
                errors++; $display("[TB] FAIL b2b_data[%0d]: got addr=%h expected %h", t, o.addr, ea);
            end
            ref_last = w;
        end
        persist = 0;
        clear_inputs();
    endtask

    task automatic test_read_write_both();
        obs_t o;
        logic [31:0]  a = $urandom;
        logic [255:0] wd = rand_line();
        d_read = 1; d_write = 1; d_addr = a; d_wdata = wd;
        run_txn(2, rand_line(), 0, o);
        checks++;
        if (o.wr !== 1'b1 || o.rd !== 1'b0) begin
            errors++; $display("[TB] FAIL rw_both_op: got rd=%b wr=%b expected rd=0 wr=1", o.rd, o.wr);
        end
        checks++;
        if (o.n_d != 1 || o.n_i != 0 || o.addr !== a || o.wdata !== wd) begin
            errors++; $display("[TB] FAIL rw_both_txn: got d=%0d i=%0d addr=%h expected d=1 i=0 addr=%h", o.n_d, o.n_i, o.addr, a);
        end
        ref_last = 1;
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        obs_t o;
        logic [31:0] ia = $urandom;
        logic [255:0] ln = rand_line();
        d_read = 1; d_addr = $urandom;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (l2_read !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_mid_pending: got l2_read=%b expected 1", l2_read);
        end
        rst = 1; l2_resp = 1; l2_rdata = rand_line();
        #1;
        checks++;
        if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0 || l2_addr !== 0 || d_rdata !== '0) begin
            errors++; $display("[TB] FAIL rst_mid_outputs: got ctrl=%b addr=%h expected 0",
                               {l2_read, l2_write, i_resp, d_resp}, l2_addr);
        end
        @(negedge clk);
        rst = 0; l2_resp = 0; d_read = 0;
        ref_last = 1;
        @(posedge clk); #1;
        checks++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_abandon: got rd=%b wr=%b expected 0 0", l2_read, l2_write);
        end
        i_read = 1; i_addr = ia;
        run_txn(2, ln, 0, o);
        checks++;
        if (o.rd !== 1'b1 || o.addr !== ia || o.n_i != 1 || o.n_d != 0 || o.rdata_i !== ln) begin
            errors++; $display("[TB] FAIL rst_mid_after: got rd=%b addr=%h i=%0d d=%0d expected I read of %h",
                               o.rd, o.addr, o.n_i, o.n_d, ia);
        end
        ref_last = 0;
        clear_inputs();
    endtask

    task automatic test_addr_change();
        obs_t o;
        logic [31:0] a = $urandom;
        d_read = 1; d_addr = a;
        run_txn(4, rand_line(), 1, o);
        checks++;
        if (o.addr !== a || !o.stable) begin
            errors++; $display("[TB] FAIL addr_hold: got addr=%h stable=%0d expected %h stable=1", o.addr, o.stable, a);
        end
        ref_last = 1;
        clear_inputs();
    endtask

    task automatic test_resp_in_idle();
        @(posedge clk); #1;
        l2_resp = 1; l2_rdata = rand_line();
        @(negedge clk);
        checks++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== '0 || d_rdata !== '0) begin
            errors++; $display("[TB] FAIL idle_resp: got i=%b d=%b expected 0 0", i_resp, d_resp);
        end
        @(posedge clk); #1;
        l2_resp = 0;
        @(negedge clk);
        checks++;
        if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
            errors++; $display("[TB] FAIL idle_stay: got rd=%b wr=%b expected 0 0", l2_read, l2_write);
        end
    endtask

    task automatic test_random();
        obs_t o;
        int   w;
        logic [31:0]  ea;
        logic [255:0] ew, ln;
        logic         e_wr;
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                i_read = 0; d_read = 0; d_write = 0;
                @(posedge clk); #1;
                i_read = 1'($urandom_range(0, 1));
                d_read = 1'($urandom_range(0, 1));
                d_write = 1'($urandom_range(0, 1));
                if (!i_read && !d_read && !d_write) i_read = 1;
            end else if (!i_read && !d_read && !d_write) begin
                d_write = 1'($urandom_range(0, 1)); d_read = 1'($urandom_range(0, 1));
                if (!d_read && !d_write) i_read = 1;
            end
            i_addr = $urandom; d_addr = $urandom; d_wdata = rand_line();
            w    = ref_pick(i_read, d_read | d_write, ref_last);
            e_wr = (w == 1) && d_write;
            ea   = (w == 1) ? d_addr : i_addr;
            ew   = d_wdata;
            ln   = rand_line();
            run_txn(1 + $urandom_range(0, 4), ln, $urandom_range(0, 1) == 1, o);
            checks++;
            if (o.n_i != ((w == 0) ? 1 : 0) || o.n_d != ((w == 1) ? 1 : 0)) begin
                errors++; $display("[TB] FAIL rnd_grant[%0d]: got i=%0d d=%0d expected side %0d", t, o.n_i, o.n_d, w);
            end
            checks++;
            if (o.wr !== e_wr || o.rd !== !e_wr || o.addr !== ea || (e_wr && o.wdata !== ew)) begin
                errors++; $display("[TB] FAIL rnd_req[%0d]: got rd=%b wr=%b addr=%h expected wr=%b addr=%h",
                                   t, o.rd, o.wr, o.addr, e_wr, ea);
            end
            checks++;
            if (((w == 0) ? o.rdata_i : o.rdata_d) !== ln || !o.stable || !o.zero_ok || !o.idle_ok) begin
                errors++; $display("[TB] FAIL rnd_resp[%0d]: got stable=%0d zero=%0d idle=%0d expected all 1 with line %h",
                                   t, o.stable, o.zero_ok, o.idle_ok, ln);
            end
            ref_last = w;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_i_read_alone();
        test_tie_after_reset();
        test_back_to_back();
        test_read_write_both();
        test_reset_mid();
        test_addr_change();
        test_resp_in_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-requester arbiter that shares the single port of the L2 cache (and through it the L2 data array) between the L1 instruction cache and the L1 data cache. It accepts one line-sized miss or writeback at a time, forwards it to L2, and returns the L2 response to the requester that owns the grant. Ties are broken round-robin so neither L1 can starve the other.

## Interface
- s_offset, 5, log2 bytes per line; line width s_line = 8*2^s_offset (256 bits)
- s_addr, 32, address width
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_addr  in  s_addr  I-cache line address
- i_rdata  out  s_line  line returned to I-cache, valid when i_resp=1
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read, d_write  in  1  D-cache line read / writeback request, held until d_resp
- d_addr  in  s_addr  D-cache line address
- d_wdata  in  s_line  writeback line
- d_rdata  out  s_line  line returned to D-cache, valid when d_resp=1
- d_resp  out  1  one-cycle completion pulse to D-cache
- l2_read, l2_write  out  1  request to L2, held until l2_resp
- l2_addr  out  s_addr  L2 request address
- l2_wdata  out  s_line  L2 write line
- l2_rdata  in  s_line  L2 read line, valid when l2_resp=1
- l2_resp  in  1  one-cycle L2 completion pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D. Register last_grant (0=I, 1=D).
- IDLE: only I requests -> SERVE_I; only D (read or write) -> SERVE_D; both -> side not equal to last_grant; none -> stay.
- On the IDLE->SERVE transition, latch op (read/write), address and wdata of the winner into output registers; l2_read/l2_write driven from these registers, never combinationally from requester inputs.
- d_read and d_write both high: write wins; read not performed.
- SERVE_x: hold l2_* stable until l2_resp=1; in that cycle assert x_resp=1 combinationally and drive x_rdata = l2_rdata; clear l2_read/l2_write, set last_grant=x, go IDLE.
- Non-granted requester's resp is 0; its rdata holds 0.
- l2_resp while IDLE is ignored (no resp, no state change).
- Requester input changes during SERVE are ignored (address/data already latched).

## Timing
- Reset (async): state=IDLE, last_grant=1 (I wins first tie), l2_read=l2_write=0, l2_addr=0, l2_wdata=0, i_resp=d_resp=0, i_rdata=d_rdata=0.
- Request sampled in IDLE at edge N -> l2_read/l2_write high from cycle N+1.
- l2_resp at cycle M -> x_resp in cycle M (zero added latency); IDLE at M+1.
- Minimum occupancy per transaction: 1 IDLE cycle + L2 latency; back-to-back requests from alternating sides are granted with one IDLE cycle between.
- Requester must drop its request in cycle M+1; arbitration in M+1 samples the dropped value.
- Reset mid-transaction: outstanding L2 request abandoned, no resp pulse issued.

## Structure
- Package l2_arb_pkg: enum arb_state_t {IDLE, SERVE_I, SERVE_D}; localparams for s_line and grant encoding.
- One sub-module: l2_arb_rr, 2-way round-robin pick (inputs req[1:0], last_grant; output grant, valid); combinational, reusable for a future prefetcher port.

## Test plan
- I read 0x0000_1000 alone, L2 responds after 3 cycles with 0xA5-pattern line -> l2_read high cycles 1-3, i_resp pulses once with i_rdata=pattern, d_resp stays 0.
- I read and D write (addr 0x0000_2000, wdata all 0x5A) same cycle after reset -> I served first, then D; l2_write with wdata=0x5A line only in second transaction.
- Both sides request continuously for 6 transactions -> grants alternate I,D,I,D,I,D.
- d_read=d_write=1 -> only l2_write asserted, d_resp once.
- rst pulsed while SERVE_D awaiting l2_resp -> all outputs 0 immediately, no d_resp; next I request served normally.
- d_addr changed mid-SERVE_D -> l2_addr keeps original value until l2_resp.
